// File: rtl/operm_ctrl_burst.sv
// operm_ctrl_burst: control-path join for the output permutation stage.
// Queues {code, burst length} control words from the kp source and opens the
// data path for exactly len+1 beats per legal word; illegal codes are dropped.
// Optional statistics counters are built when OPERM_CTRL_STATS_EN is defined;
// otherwise stat_beats / stat_drops are tied to zero.

module operm_ctrl_burst #(
  parameter int unsigned          SELW       = 4,
  parameter int unsigned          LENW       = 4,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [2**SELW-1:0]   VALID_MASK = {2**SELW{1'b1}},
  parameter int unsigned          CNTW       = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            t_kp_req,
  output logic            t_kp_ack,
  input  logic [SELW-1:0] k_ctrl,
  input  logic [LENW-1:0] k_len,
  input  logic            t_dat_req,
  output logic            t_dat_ack,
  output logic            i_dat_req,
  input  logic            i_dat_ack,
  output logic [SELW-1:0] i_ctrl,
  output logic            i_last,
  output logic            err_invalid,
  output logic [CNTW-1:0] stat_beats,
  output logic [CNTW-1:0] stat_drops
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned OCCW = PTRW + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Registered state
  state_e          state_q, state_d;
  logic [SELW-1:0] ctrl_mem_q [DEPTH];
  logic [LENW-1:0] len_mem_q  [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0] count_q, count_d;
  logic [LENW-1:0] beat_cnt_q, beat_cnt_d;
  logic [SELW-1:0] last_ctrl_q, last_ctrl_d;
  logic            err_q, err_d;

  // Combinational helpers
  logic            full_s;
  logic            illegal_s;
  logic            kp_ack_s;
  logic            push_s;
  logic            drop_s;
  logic            run_s;
  logic [SELW-1:0] head_ctrl_s;
  logic [LENW-1:0] head_len_s;
  logic            last_s;
  logic            xfer_s;
  logic            pop_s;

  // Handshake decode: the kp ack is gated by reset_n so it is low while reset is held
  always_comb begin
    full_s      = (count_q == OCCW'(DEPTH));
    illegal_s   = ~VALID_MASK[k_ctrl];
    kp_ack_s    = reset_n & t_kp_req & (~full_s | illegal_s);
    push_s      = kp_ack_s & ~illegal_s;
    drop_s      = kp_ack_s & illegal_s;
    run_s       = (state_q == ST_RUN);
    head_ctrl_s = ctrl_mem_q[rd_ptr_q];
    head_len_s  = len_mem_q[rd_ptr_q];
    last_s      = run_s & (beat_cnt_q == head_len_s);
    xfer_s      = run_s & t_dat_req & i_dat_ack;
    pop_s       = xfer_s & last_s;
  end

  // Next-state computation for queue pointers, occupancy, beat counter and FSM
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_cnt_d  = beat_cnt_q;
    last_ctrl_d = last_ctrl_q;
    err_d       = drop_s;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + OCCW'(1);
      2'b01:   count_d = count_q - OCCW'(1);
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      beat_cnt_d = {LENW{1'b0}};
    end else if (xfer_s) begin
      beat_cnt_d = beat_cnt_q + LENW'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    // Remember the code being applied so i_ctrl can hold it once the queue drains
    if (run_s) begin
      last_ctrl_d = head_ctrl_s;
    end else begin
      last_ctrl_d = last_ctrl_q;
    end

    // RUN exactly while a word sits at the queue head
    if (count_d != {OCCW{1'b0}}) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Control FSM, queue storage and pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {PTRW{1'b0}};
      rd_ptr_q    <= {PTRW{1'b0}};
      count_q     <= {OCCW{1'b0}};
      beat_cnt_q  <= {LENW{1'b0}};
      last_ctrl_q <= {SELW{1'b0}};
      err_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctrl_mem_q[i] <= {SELW{1'b0}};
        len_mem_q[i]  <= {LENW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      last_ctrl_q <= last_ctrl_d;
      err_q       <= err_d;
      if (push_s) begin
        ctrl_mem_q[wr_ptr_q] <= k_ctrl;
        len_mem_q[wr_ptr_q]  <= k_len;
      end
    end
  end

  // Output steering: data path is a pure req/ack pass-through while RUN
  always_comb begin
    t_kp_ack    = kp_ack_s;
    i_dat_req   = run_s & t_dat_req;
    t_dat_ack   = run_s & i_dat_ack;
    i_last      = last_s;
    err_invalid = err_q;
    if (run_s) begin
      i_ctrl = head_ctrl_s;
    end else begin
      i_ctrl = last_ctrl_q;
    end
  end

`ifdef OPERM_CTRL_STATS_EN
  logic [CNTW-1:0] stat_beats_q, stat_beats_d;
  logic [CNTW-1:0] stat_drops_q, stat_drops_d;

  // Saturating statistics next-state
  always_comb begin
    if (xfer_s && (stat_beats_q != {CNTW{1'b1}})) begin
      stat_beats_d = stat_beats_q + CNTW'(1);
    end else begin
      stat_beats_d = stat_beats_q;
    end
    if (drop_s && (stat_drops_q != {CNTW{1'b1}})) begin
      stat_drops_d = stat_drops_q + CNTW'(1);
    end else begin
      stat_drops_d = stat_drops_q;
    end
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_beats_q <= {CNTW{1'b0}};
      stat_drops_q <= {CNTW{1'b0}};
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_drops_q <= stat_drops_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_drops = stat_drops_q;
`else
  assign stat_beats = {CNTW{1'b0}};
  assign stat_drops = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_operm_ctrl_burst.sv
// Self-checking bench for operm_ctrl_burst: a queue-based reference model is
// compared against the DUT on every negative clock edge, with directed
// sequences that also pin hand-computed literal expectations.
`timescale 1ns/1ps

module tb_operm_ctrl_burst;

  localparam int SELW = 4;
  localparam int LENW = 4;
  localparam int DEPTH = 4;
  localparam int CNTW = 16;
  localparam logic [15:0] MASK = 16'h00FF;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            t_kp_req = 1'b0;
  logic            t_kp_ack;
  logic [SELW-1:0] k_ctrl = 4'd0;
  logic [LENW-1:0] k_len = 4'd0;
  logic            t_dat_req = 1'b0;
  logic            t_dat_ack;
  logic            i_dat_req;
  logic            i_dat_ack = 1'b0;
  logic [SELW-1:0] i_ctrl;
  logic            i_last;
  logic            err_invalid;
  logic [CNTW-1:0] stat_beats;
  logic [CNTW-1:0] stat_drops;

  int checks = 0;
  int failures = 0;

  operm_ctrl_burst #(
    .SELW(SELW), .LENW(LENW), .DEPTH(DEPTH), .VALID_MASK(MASK), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .t_kp_req(t_kp_req), .t_kp_ack(t_kp_ack), .k_ctrl(k_ctrl), .k_len(k_len),
    .t_dat_req(t_dat_req), .t_dat_ack(t_dat_ack),
    .i_dat_req(i_dat_req), .i_dat_ack(i_dat_ack),
    .i_ctrl(i_ctrl), .i_last(i_last), .err_invalid(err_invalid),
    .stat_beats(stat_beats), .stat_drops(stat_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] c;
    logic [3:0] l;
  } word_t;

  word_t      mq[$];
  int         beat = 0;
  logic [3:0] last_c = 4'd0;
  bit         err_p = 1'b0;
  int         m_beats = 0;
  int         m_drops = 0;

  function automatic int exp_stat(input int v);
`ifdef OPERM_CTRL_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Per-cycle compare against the model, then advance the model by one clock
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_kp_ack", 32'(t_kp_ack), 32'd0);
      chk("rst_dat_ack", 32'(t_dat_ack), 32'd0);
      chk("rst_i_req", 32'(i_dat_req), 32'd0);
      chk("rst_i_ctrl", 32'(i_ctrl), 32'd0);
      chk("rst_i_last", 32'(i_last), 32'd0);
      chk("rst_err", 32'(err_invalid), 32'd0);
      chk("rst_stat_beats", 32'(stat_beats), 32'd0);
      chk("rst_stat_drops", 32'(stat_drops), 32'd0);
      mq.delete();
      beat = 0;
      last_c = 4'd0;
      err_p = 1'b0;
      m_beats = 0;
      m_drops = 0;
    end else begin
      bit run, full, legal, e_kp, e_last, xfer;
      logic [3:0] e_ctrl;
      run   = (mq.size() != 0);
      full  = (mq.size() == DEPTH);
      legal = MASK[k_ctrl];
      e_kp  = t_kp_req && (!full || !legal);
      e_ctrl = run ? mq[0].c : last_c;
      e_last = run && (beat == int'(mq[0].l));
      chk("kp_ack", 32'(t_kp_ack), 32'(e_kp));
      chk("t_dat_ack", 32'(t_dat_ack), 32'(run && i_dat_ack));
      chk("i_dat_req", 32'(i_dat_req), 32'(run && t_dat_req));
      chk("i_ctrl", 32'(i_ctrl), 32'(e_ctrl));
      chk("i_last", 32'(i_last), 32'(e_last));
      chk("err_invalid", 32'(err_invalid), 32'(err_p));
      chk("stat_beats", 32'(stat_beats), 32'(exp_stat(m_beats)));
      chk("stat_drops", 32'(stat_drops), 32'(exp_stat(m_drops)));
      // advance
      xfer = run && t_dat_req && i_dat_ack;
      if (run) last_c = mq[0].c;
      if (xfer) begin
        if (m_beats < 65535) m_beats++;
        if (e_last) begin
          void'(mq.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
      if (e_kp && legal) mq.push_back('{c: k_ctrl, l: k_len});
      err_p = e_kp && !legal;
      if (err_p && m_drops < 65535) m_drops++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit kr, input logic [3:0] kc, input logic [3:0] kl,
                      input bit dr, input bit da);
    @(posedge clk);
    #1;
    t_kp_req = kr; k_ctrl = kc; k_len = kl; t_dat_req = dr; i_dat_ack = da;
    @(negedge clk);
    #1;
  endtask

  task automatic rnd_step();
    logic [3:0] kc, kl;
    int sel;
    kc = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
    sel = $urandom_range(0, 3);
    kl = (sel == 0) ? 4'd0 : (sel == 1) ? 4'd15 : 4'($urandom_range(0, 3));
    step(bit'($urandom_range(0, 1)), kc, kl, $urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // 1: single word {3,len 2}, 3 beats then idle
    step(1'b1, 4'd3, 4'd2, 1'b1, 1'b1);
    chk("t1_kp_ack", 32'(t_kp_ack), 32'd1);
    chk("t1_idle_req", 32'(i_dat_req), 32'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t1_b0_ctrl", 32'(i_ctrl), 32'd3);
    chk("t1_b0_last", 32'(i_last), 32'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t1_b1_last", 32'(i_last), 32'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t1_b2_last", 32'(i_last), 32'd1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t1_done_req", 32'(i_dat_req), 32'd0);
    chk("t1_hold_ctrl", 32'(i_ctrl), 32'd3);

    // 2: illegal code 9 dropped
    step(1'b1, 4'd9, 4'd0, 1'b0, 1'b0);
    chk("t2_kp_ack", 32'(t_kp_ack), 32'd1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t2_err", 32'(err_invalid), 32'd1);
    chk("t2_no_beat", 32'(i_dat_req), 32'd0);
    chk("t2_drops", 32'(stat_drops), 32'(exp_stat(1)));
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("t2_err_gone", 32'(err_invalid), 32'd0);

    // 3: fill the queue, 5th stalls until the cycle after a pop
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 4'(i), 4'd1, 1'b0, 1'b0);
      chk("t3_fill_ack", 32'(t_kp_ack), 32'd1);
    end
    step(1'b1, 4'd5, 4'd1, 1'b0, 1'b0);
    chk("t3_full_stall", 32'(t_kp_ack), 32'd0);
    step(1'b1, 4'd5, 4'd1, 1'b1, 1'b1);
    chk("t3_b0_stall", 32'(t_kp_ack), 32'd0);
    step(1'b1, 4'd5, 4'd1, 1'b1, 1'b1);
    chk("t3_pop_stall", 32'(t_kp_ack), 32'd0);
    chk("t3_pop_last", 32'(i_last), 32'd1);
    step(1'b1, 4'd5, 4'd1, 1'b1, 1'b1);
    chk("t3_after_pop_ack", 32'(t_kp_ack), 32'd1);
    repeat (10) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t3_drained", 32'(i_dat_req), 32'd0);

    // 4: back-to-back {1,0},{2,1}
    step(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 4'd1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t4_b0_ctrl", 32'(i_ctrl), 32'd1);
    chk("t4_b0_last", 32'(i_last), 32'd1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t4_b1_ctrl", 32'(i_ctrl), 32'd2);
    chk("t4_b1_last", 32'(i_last), 32'd0);
    chk("t4_b1_req", 32'(i_dat_req), 32'd1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t4_b2_ctrl", 32'(i_ctrl), 32'd2);
    chk("t4_b2_last", 32'(i_last), 32'd1);

    // 5: long burst with randomly toggling downstream ack
    step(1'b1, 4'd4, 4'd7, 1'b0, 1'b0);
    repeat (30) step(1'b0, 4'd0, 4'd0, 1'b1, bit'($urandom_range(0, 1)));
    repeat (10) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);

    // random traffic
    repeat (400) rnd_step();
    repeat (80) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);

    // 6: reset in the middle of a 4-beat burst
    step(1'b1, 4'd5, 4'd3, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    t_kp_req = 1'b1; k_ctrl = 4'd2; k_len = 4'd0; t_dat_req = 1'b1; i_dat_ack = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("t6_async_i_req", 32'(i_dat_req), 32'd0);
    chk("t6_async_dat_ack", 32'(t_dat_ack), 32'd0);
    chk("t6_async_kp_ack", 32'(t_kp_ack), 32'd0);
    chk("t6_async_ctrl", 32'(i_ctrl), 32'd0);
    chk("t6_async_last", 32'(i_last), 32'd0);
    @(negedge clk);
    #1;
    t_kp_req = 1'b0; t_dat_req = 1'b0; i_dat_ack = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t6_empty_after", 32'(i_dat_req), 32'd0);
    step(1'b1, 4'd6, 4'd1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t6_new_ctrl", 32'(i_ctrl), 32'd6);
    chk("t6_new_b0_last", 32'(i_last), 32'd0);
    step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    chk("t6_new_b1_last", 32'(i_last), 32'd1);

    repeat (200) rnd_step();
    repeat (80) step(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
